// File: rtl/mips_single_cycle_cpu.sv
// Single-cycle 32-bit MIPS-subset processor: add/sub/and/or/mul, addi, lw, sw, beq, j.
// One instruction commits per rising edge while start_i is high.

module ProgramCounter (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic [31:0] pc_d,
    output logic [31:0] pc_o
);
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            pc_o <= '0;
        else if (en_i)
            pc_o <= pc_d;
    end
endmodule

module InstructionMemory #(
    parameter int WORDS = 256,
    parameter int AW    = 8
) (
    input  logic          clk_i,
    input  logic          loadEn_i,
    input  logic [AW-1:0] loadAddr_i,
    input  logic [31:0]   loadData_i,
    input  logic [AW-1:0] addr_i,
    output logic [31:0]   instr_o
);
    logic [31:0] memory [0:WORDS-1];

    // Load port lets the program image be written; the core itself ties it off
    always_ff @(posedge clk_i) begin
        if (loadEn_i)
            memory[loadAddr_i] <= loadData_i;
    end

    assign instr_o = memory[addr_i];
endmodule

module RegisterFile (
    input  logic        clk_i,
    input  logic        we_i,
    input  logic [4:0]  raddrA_i,
    input  logic [4:0]  raddrB_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdataA_o,
    output logic [31:0] rdataB_o
);
    logic [31:0] register [0:31];

    always_ff @(posedge clk_i) begin
        if (we_i && (waddr_i != 5'd0))
            register[waddr_i] <= wdata_i;
    end

    assign rdataA_o = (raddrA_i == 5'd0) ? 32'd0 : register[raddrA_i];
    assign rdataB_o = (raddrB_i == 5'd0) ? 32'd0 : register[raddrB_i];
endmodule

module DataMemory #(
    parameter int WORDS = 32,
    parameter int AW    = 5
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);
    logic [31:0] memory [0:WORDS-1];

    always_ff @(posedge clk_i) begin
        if (we_i)
            memory[addr_i] <= wdata_i;
    end

    assign rdata_o = memory[addr_i];
endmodule

module mips_single_cycle_cpu #(
    parameter int IMEM_WORDS = 256,
    parameter int DMEM_WORDS = 32
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i
);
    localparam int IAW = $clog2(IMEM_WORDS);
    localparam int DAW = $clog2(DMEM_WORDS);

    logic [31:0] pc;
    logic [31:0] pcPlus4;
    logic [31:0] nextPc;
    logic [31:0] instr;
    logic [31:0] rsVal;
    logic [31:0] rtVal;
    logic [31:0] signExt;
    logic [31:0] effAddr;
    logic [31:0] aluResult;
    logic [31:0] wbData;
    logic [31:0] dmemRdata;
    logic [4:0]  writeReg;
    logic        regWrite;
    logic        memWrite;
    logic        memToReg;
    logic        unusedBits;

    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;

    assign opcode  = instr[31:26];
    assign rs      = instr[25:21];
    assign rt      = instr[20:16];
    assign rd      = instr[15:11];
    assign funct   = instr[5:0];
    assign signExt = {{16{instr[15]}}, instr[15:0]};
    assign pcPlus4 = pc + 32'd4;
    assign effAddr = rsVal + signExt;
    assign wbData  = memToReg ? dmemRdata : aluResult;

    assign unusedBits = ^{instr[10:6], effAddr[31:DAW+2], effAddr[1:0]};

    ProgramCounter PC (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (start_i),
        .pc_d  (nextPc),
        .pc_o  (pc)
    );

    InstructionMemory #(.WORDS(IMEM_WORDS), .AW(IAW)) Instruction_Memory (
        .clk_i      (clk_i),
        .loadEn_i   (1'b0),
        .loadAddr_i ('0),
        .loadData_i ('0),
        .addr_i     (pc[IAW+1:2]),
        .instr_o    (instr)
    );

    RegisterFile Registers (
        .clk_i    (clk_i),
        .we_i     (regWrite && start_i && !rst_i),
        .raddrA_i (rs),
        .raddrB_i (rt),
        .waddr_i  (writeReg),
        .wdata_i  (wbData),
        .rdataA_o (rsVal),
        .rdataB_o (rtVal)
    );

    DataMemory #(.WORDS(DMEM_WORDS), .AW(DAW)) Data_Memory (
        .clk_i   (clk_i),
        .we_i    (memWrite && start_i && !rst_i),
        .addr_i  (effAddr[DAW+1:2]),
        .wdata_i (rtVal),
        .rdata_o (dmemRdata)
    );

    // Decode and execute; anything not recognised falls through as a NOP
    always_comb begin
        regWrite  = 1'b0;
        memWrite  = 1'b0;
        memToReg  = 1'b0;
        writeReg  = rt;
        aluResult = effAddr;
        nextPc    = pcPlus4;
        case (opcode)
            6'b000000: begin
                writeReg = rd;
                regWrite = 1'b1;
                case (funct)
                    6'b100000: aluResult = rsVal + rtVal;
                    6'b100010: aluResult = rsVal - rtVal;
                    6'b100100: aluResult = rsVal & rtVal;
                    6'b100101: aluResult = rsVal | rtVal;
                    6'b011000: aluResult = rsVal * rtVal;
                    default:   regWrite  = 1'b0;
                endcase
            end
            6'b001000: regWrite = 1'b1;
            6'b100011: begin
                regWrite = 1'b1;
                memToReg = 1'b1;
            end
            6'b101011: memWrite = 1'b1;
            6'b000100: begin
                if (rsVal == rtVal)
                    nextPc = pcPlus4 + {signExt[29:0], 2'b00};
            end
            6'b000010: nextPc = {pcPlus4[31:28], instr[25:0], 2'b00};
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mips_single_cycle_cpu.sv
// Directed testbench for mips_single_cycle_cpu: programs are preloaded hierarchically
// and architectural state is compared against hand-computed values.

module tb_mips_single_cycle_cpu;
    logic clock;
    logic reset;
    logic start;

    int checkCount = 0;
    int errorCount = 0;

    mips_single_cycle_cpu dut (
        .clk_i   (clock),
        .rst_i   (reset),
        .start_i (start)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] rType(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] funct);
        return {6'b000000, rs, rt, rd, 5'd0, funct};
    endfunction

    function automatic logic [31:0] iType(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic loadWord(input logic [7:0] idx, input logic [31:0] word);
        dut.Instruction_Memory.memory[idx] <= word;
    endtask

    // Clears the low program area and returns PC to 0 between clock edges
    task automatic newProgram();
        for (int i = 0; i < 32; i++)
            dut.Instruction_Memory.memory[i] <= 32'd0;
        reset = 1'b1;
        #1;
        reset = 1'b0;
        #1;
    endtask

    // Runs n edges with start high, then parks at a falling edge with start low
    task automatic applyStimulus(input int n);
        start = 1'b1;
        repeat (n) @(posedge clock);
        @(negedge clock);
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 256; i++)
            dut.Instruction_Memory.memory[i] <= 32'd0;
        for (int i = 0; i < 32; i++) begin
            dut.Registers.register[i] <= 32'd0;
            dut.Data_Memory.memory[i] <= 32'd0;
        end
        #1;

        // Reset dominates start; PC holds with start low, then counts through NOPs
        reset = 1'b1;
        start = 1'b1;
        @(posedge clock); #1;
        checkOutput("pc_in_reset", dut.PC.pc_o, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        start = 1'b0;
        @(posedge clock); #1;
        checkOutput("pc_hold_start_low", dut.PC.pc_o, 32'd0);
        @(negedge clock);
        start = 1'b1;
        @(posedge clock); #1;
        checkOutput("pc_step_4", dut.PC.pc_o, 32'd4);
        @(posedge clock); #1;
        checkOutput("pc_step_8", dut.PC.pc_o, 32'd8);
        @(posedge clock); #1;
        checkOutput("pc_step_12", dut.PC.pc_o, 32'd12);
        @(negedge clock);
        start = 1'b0;

        // ALU operations
        newProgram();
        loadWord(8'd0, iType(6'b001000, 5'd0, 5'd8, 16'd10));
        loadWord(8'd1, iType(6'b001000, 5'd0, 5'd9, 16'd3));
        loadWord(8'd2, rType(5'd8, 5'd9, 5'd10, 6'b100000));
        loadWord(8'd3, rType(5'd8, 5'd9, 5'd11, 6'b100010));
        loadWord(8'd4, rType(5'd8, 5'd9, 5'd12, 6'b100100));
        loadWord(8'd5, rType(5'd8, 5'd9, 5'd13, 6'b100101));
        loadWord(8'd6, rType(5'd8, 5'd9, 5'd14, 6'b011000));
        #1;
        applyStimulus(7);
        checkOutput("alu_pc", dut.PC.pc_o, 32'd28);
        checkOutput("addi_r8", dut.Registers.register[8], 32'd10);
        checkOutput("addi_r9", dut.Registers.register[9], 32'd3);
        checkOutput("add_r10", dut.Registers.register[10], 32'd13);
        checkOutput("sub_r11", dut.Registers.register[11], 32'd7);
        checkOutput("and_r12", dut.Registers.register[12], 32'd2);
        checkOutput("or_r13", dut.Registers.register[13], 32'd11);
        checkOutput("mul_r14", dut.Registers.register[14], 32'd30);

        // Negative immediates, wraparound and writes to $0
        newProgram();
        loadWord(8'd0, iType(6'b001000, 5'd0, 5'd8, 16'hFFFF));
        loadWord(8'd1, rType(5'd8, 5'd8, 5'd9, 6'b100000));
        loadWord(8'd2, iType(6'b001000, 5'd0, 5'd0, 16'd5));
        #1;
        applyStimulus(3);
        checkOutput("addi_neg_r8", dut.Registers.register[8], 32'hFFFF_FFFF);
        checkOutput("add_wrap_r9", dut.Registers.register[9], 32'hFFFF_FFFE);
        checkOutput("r0_stays_zero", dut.Registers.register[0], 32'd0);

        // Store then load through data memory word 2
        newProgram();
        loadWord(8'd0, iType(6'b001000, 5'd0, 5'd8, 16'd7));
        loadWord(8'd1, iType(6'b101011, 5'd0, 5'd8, 16'd8));
        loadWord(8'd2, iType(6'b100011, 5'd0, 5'd9, 16'd8));
        #1;
        applyStimulus(3);
        checkOutput("lw_r9", dut.Registers.register[9], 32'd7);
        checkOutput("sw_dmem2", dut.Data_Memory.memory[2], 32'd7);

        // Control flow: taken beq, untaken beq, jump
        newProgram();
        loadWord(8'd0, iType(6'b000100, 5'd0, 5'd0, 16'd2));
        #1;
        applyStimulus(1);
        checkOutput("beq_taken_pc", dut.PC.pc_o, 32'd12);

        newProgram();
        loadWord(8'd0, iType(6'b000100, 5'd8, 5'd0, 16'd2));
        #1;
        applyStimulus(1);
        checkOutput("beq_untaken_pc", dut.PC.pc_o, 32'd4);

        newProgram();
        loadWord(8'd0, {6'b000010, 26'h10});
        #1;
        applyStimulus(1);
        checkOutput("jump_pc", dut.PC.pc_o, 32'd64);

        // Asynchronous reset mid-program leaves registers intact
        newProgram();
        #1;
        applyStimulus(5);
        checkOutput("pc_before_reset", dut.PC.pc_o, 32'd20);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("pc_async_reset", dut.PC.pc_o, 32'd0);
        checkOutput("r8_kept", dut.Registers.register[8], 32'd7);
        checkOutput("r9_kept", dut.Registers.register[9], 32'd7);
        reset = 1'b0;
        @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end
endmodule
